// File: rtl/bmc_stream_decoder.sv
// Biphase-mark block decoder: DATA_W cells per block, boundary checking with
// cross-block continuity, registered valid/ready output, error counter, lock FSM.
module bmc_stream_decoder #(
   parameter int unsigned DATA_W   = 24,
   parameter int unsigned CNT_W    = 16,
   parameter int unsigned LOCK_N   = 4,
   parameter int unsigned UNLOCK_N = 2
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [2*DATA_W-1:0] s_block,
   input  logic                s_valid,
   output logic                s_ready,
   input  logic                chk_cont,
   input  logic                clr_cnt,
   output logic [DATA_W-1:0]   m_block,
   output logic                m_err,
   output logic                m_valid,
   input  logic                m_ready,
   output logic                locked,
   output logic [CNT_W-1:0]    err_count
);

   localparam logic [0:0] ST_HUNT   = 1'b0;
   localparam logic [0:0] ST_LOCKED = 1'b1;

   localparam int unsigned RUN_MAX = (LOCK_N > UNLOCK_N) ? LOCK_N : UNLOCK_N;
   localparam int unsigned RUN_W   = $clog2(RUN_MAX + 1);

   logic [0:0]        state;
   logic [0:0]        state_nxt;
   logic [RUN_W-1:0]  run;
   logic [RUN_W-1:0]  run_nxt;
   logic [RUN_W-1:0]  run_inc;
   logic              last_half;
   logic              first;
   logic [DATA_W-1:0] dec;
   logic              blk_err;
   logic              accept;

   assign s_ready = ~m_valid | m_ready;
   assign accept  = s_valid & s_ready;
   assign locked  = (state == ST_LOCKED);

   // Pair i+1 is sent before pair i, so its second half must differ from
   // the first half of pair i; the oldest pair is checked against the last
   // half of the previous accepted block.
   always_comb begin
      dec     = '0;
      blk_err = 1'b0;
      for (int unsigned i = 0; i < DATA_W; i++) begin
         dec[i] = s_block[2*i+1] ^ s_block[2*i];
      end
      for (int unsigned i = 0; i + 1 < DATA_W; i++) begin
         if (s_block[2*i+1] == s_block[2*i+2]) begin
            blk_err = 1'b1;
         end
      end
      if (chk_cont && !first && (s_block[2*DATA_W-1] == last_half)) begin
         blk_err = 1'b1;
      end
   end

   always_comb begin
      state_nxt = state;
      run_nxt   = run;
      run_inc   = run + RUN_W'(1);
      if (accept) begin
         case (state)
            ST_HUNT: begin
               if (blk_err) begin
                  run_nxt = '0;
               end else if (run_inc == RUN_W'(LOCK_N)) begin
                  state_nxt = ST_LOCKED;
                  run_nxt   = '0;
               end else begin
                  run_nxt = run_inc;
               end
            end
            ST_LOCKED: begin
               if (!blk_err) begin
                  run_nxt = '0;
               end else if (run_inc == RUN_W'(UNLOCK_N)) begin
                  state_nxt = ST_HUNT;
                  run_nxt   = '0;
               end else begin
                  run_nxt = run_inc;
               end
            end
            default: begin
               state_nxt = ST_HUNT;
               run_nxt   = '0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         m_valid   <= 1'b0;
         m_block   <= '0;
         m_err     <= 1'b0;
         state     <= ST_HUNT;
         run       <= '0;
         last_half <= 1'b0;
         first     <= 1'b1;
      end else begin
         state <= state_nxt;
         run   <= run_nxt;
         if (accept) begin
            m_valid   <= 1'b1;
            m_block   <= dec;
            m_err     <= blk_err;
            last_half <= s_block[0];
            first     <= 1'b0;
         end else if (m_ready) begin
            m_valid <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         err_count <= '0;
      end else if (clr_cnt) begin
         err_count <= '0;
      end else if (accept && blk_err && (err_count != '1)) begin
         err_count <= err_count + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_bmc_stream_decoder.sv
// Directed bench for bmc_stream_decoder (DATA_W=4, CNT_W=4, LOCK_N=2, UNLOCK_N=2):
// a per-cycle vector table plus hand sequences for backpressure, saturation and reset.
module tb_bmc_stream_decoder;

   logic       clk;
   logic       rst;
   logic [7:0] s_block;
   logic       s_valid;
   logic       s_ready;
   logic       chk_cont;
   logic       clr_cnt;
   logic [3:0] m_block;
   logic       m_err;
   logic       m_valid;
   logic       m_ready;
   logic       locked;
   logic [3:0] err_count;

   int checks = 0;
   int errors = 0;

   bmc_stream_decoder #(
      .DATA_W  (4),
      .CNT_W   (4),
      .LOCK_N  (2),
      .UNLOCK_N(2)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .s_block  (s_block),
      .s_valid  (s_valid),
      .s_ready  (s_ready),
      .chk_cont (chk_cont),
      .clr_cnt  (clr_cnt),
      .m_block  (m_block),
      .m_err    (m_err),
      .m_valid  (m_valid),
      .m_ready  (m_ready),
      .locked   (locked),
      .err_count(err_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] blk;
      logic       vld;
      logic       rdy;
      logic       chk;
      logic       clr;
      logic       e_sready;
      logic       e_mvalid;
      logic [3:0] e_mblock;
      logic       e_merr;
      logic       e_locked;
      logic [3:0] e_cnt;
   } vec_t;

   vec_t vecs[9];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   initial begin
      // Clean blocks: B4 -> 1010 (ends 0), B2 -> 1001 (starts 1, ends 0),
      // B5 -> 1011 (starts 1, ends 1), 4D -> 1001 (starts 0, ends 1).
      // F7 -> 0010 with internal boundary violations.
      vecs[0] = '{8'hB4, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 4'b1010, 1'b0, 1'b0, 4'd0};
      vecs[1] = '{8'hB2, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 4'b1001, 1'b0, 1'b1, 4'd0};
      vecs[2] = '{8'hF7, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 4'b0010, 1'b1, 1'b1, 4'd1};
      vecs[3] = '{8'hB5, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 4'b1011, 1'b1, 1'b0, 4'd2};
      vecs[4] = '{8'hB5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 4'b1011, 1'b0, 1'b0, 4'd2};
      vecs[5] = '{8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 4'b1011, 1'b0, 1'b0, 4'd2};
      vecs[6] = '{8'hB5, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 4'b1011, 1'b1, 1'b0, 4'd3};
      vecs[7] = '{8'hB4, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 4'b1010, 1'b1, 1'b0, 4'd0};
      vecs[8] = '{8'hB2, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 4'b1001, 1'b0, 1'b0, 4'd0};

      rst      = 1'b0;
      s_block  = '0;
      s_valid  = 1'b0;
      chk_cont = 1'b1;
      clr_cnt  = 1'b0;
      m_ready  = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_m_valid", m_valid, 0);
      chk("rst_m_block", m_block, 0);
      chk("rst_m_err", m_err, 0);
      chk("rst_locked", locked, 0);
      chk("rst_err_count", err_count, 0);
      chk("rst_s_ready", s_ready, 1);
      @(negedge clk);
      rst = 1'b1;

      for (int k = 0; k < 9; k++) begin
         @(negedge clk);
         s_block  = vecs[k].blk;
         s_valid  = vecs[k].vld;
         m_ready  = vecs[k].rdy;
         chk_cont = vecs[k].chk;
         clr_cnt  = vecs[k].clr;
         #1;
         chk($sformatf("v%0d_s_ready", k), s_ready, vecs[k].e_sready);
         @(posedge clk);
         #1;
         chk($sformatf("v%0d_m_valid", k), m_valid, vecs[k].e_mvalid);
         if (vecs[k].e_mvalid) begin
            chk($sformatf("v%0d_m_block", k), m_block, vecs[k].e_mblock);
            chk($sformatf("v%0d_m_err", k), m_err, vecs[k].e_merr);
         end
         chk($sformatf("v%0d_locked", k), locked, vecs[k].e_locked);
         chk($sformatf("v%0d_err_count", k), err_count, vecs[k].e_cnt);
      end
      clr_cnt = 1'b0;

      // Backpressure: output 1001 is held while a new B4 waits.
      @(negedge clk);
      s_block  = 8'hB4;
      s_valid  = 1'b1;
      m_ready  = 1'b0;
      chk_cont = 1'b1;
      for (int k = 0; k < 3; k++) begin
         #1;
         chk($sformatf("bp%0d_s_ready", k), s_ready, 0);
         @(posedge clk);
         #1;
         chk($sformatf("bp%0d_m_valid", k), m_valid, 1);
         chk($sformatf("bp%0d_m_block", k), m_block, 4'b1001);
         @(negedge clk);
      end
      m_ready = 1'b1;
      #1;
      chk("bp_rel_s_ready", s_ready, 1);
      @(posedge clk);
      #1;
      chk("bp_rel_m_block", m_block, 4'b1010);
      chk("bp_rel_m_err", m_err, 0);
      chk("bp_rel_locked", locked, 1);
      @(negedge clk);
      s_block = 8'hB2;
      @(posedge clk);
      #1;
      chk("bp_next_m_block", m_block, 4'b1001);
      chk("bp_next_m_valid", m_valid, 1);
      @(negedge clk);
      s_valid = 1'b0;
      @(posedge clk);
      #1;
      chk("bp_drain_m_valid", m_valid, 0);

      // Saturation of the error counter.
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         s_block = 8'hF7;
         s_valid = 1'b1;
         @(posedge clk);
         #1;
         chk($sformatf("sat%0d_err_count", k), err_count, (k + 1 > 15) ? 15 : k + 1);
      end
      @(negedge clk);
      clr_cnt = 1'b1;
      @(posedge clk);
      #1;
      chk("clr_err_count", err_count, 0);
      chk("clr_m_err", m_err, 1);
      @(negedge clk);
      clr_cnt = 1'b0;

      // Asynchronous reset while an output block is held.
      #2;
      rst = 1'b0;
      #1;
      chk("arst_m_valid", m_valid, 0);
      chk("arst_err_count", err_count, 0);
      @(negedge clk);
      rst     = 1'b1;
      s_block = 8'h4D;
      s_valid = 1'b1;
      @(posedge clk);
      #1;
      chk("post_rst_m_block", m_block, 4'b1001);
      chk("post_rst_first_m_err", m_err, 0);
      @(negedge clk);
      s_block = 8'hB5;
      @(posedge clk);
      #1;
      chk("post_rst_cont_m_err", m_err, 1);
      chk("post_rst_err_count", err_count, 1);
      @(negedge clk);
      s_valid = 1'b0;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
